// File: rtl/alu_issue_ctrl_if.sv
// ============================================================================
//  Module      : alu_issue_ctrl_if
//  Description : Bundle of the command, ALU-side and result signals of the
//                ALU issue controller.
//                  slave  - view taken by alu_issue_ctrl
//                  master - view taken by the surrounding datapath / ALU
//  Signals     : cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op  command channel
//                alu_a/alu_b/alu_op                      operands to the ALU
//                alu_result/alu_cf/alu_sf/alu_zf         ALU outputs
//                res_valid/res_ready/res_data/res_*f     result channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_ctrl_if #(
   parameter int WIDTH = 7
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_op;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cf;
   logic             alu_sf;
   logic             alu_zf;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_cf;
   logic             res_sf;
   logic             res_zf;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op,
      input  alu_result, alu_cf, alu_sf, alu_zf,
      input  res_ready,
      output cmd_ready,
      output alu_a, alu_b, alu_op,
      output res_valid, res_data, res_cf, res_sf, res_zf
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op,
      output alu_result, alu_cf, alu_sf, alu_zf,
      output res_ready,
      input  cmd_ready,
      input  alu_a, alu_b, alu_op,
      input  res_valid, res_data, res_cf, res_sf, res_zf
   );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Flow-controlled front/back end for a combinational ALU.
//                Commands {op, a, b} are queued in a DEPTH-entry FIFO, popped
//                into registered ALU operands, and the ALU result and flags
//                are captured one cycle later and offered on a valid/ready
//                result channel. One result per two cycles at full rate.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - synchronous active-low reset
//                bus      - alu_issue_ctrl_if.slave (command, ALU, result)
//                busy     - FSM not idle or FIFO not empty
//                op_count - saturating result-handshake count
//                           (only when ALU_ISSUE_OPCNT_EN is defined)
//  Options     : ALU_ISSUE_OPCNT_EN - adds the op_count output and counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_issue_ctrl_if.slave     bus,
`ifdef ALU_ISSUE_OPCNT_EN
   output logic [7:0]          op_count,
`endif
   output logic                busy
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_EW = 2 * WIDTH + 1;
   localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------------
   logic [c_EW-1:0]  r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;

   state_t           r_state;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_alu_op;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_cf;
   logic             r_res_sf;
   logic             r_res_zf;

   logic             w_cmd_ready;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [c_EW-1:0]  w_head;

   // Ready comes only from the registered count, so a pop while full does not
   // reopen the FIFO until the following cycle.
   assign w_cmd_ready = (r_count != c_FULL);
   assign w_empty     = (r_count == '0);
   assign w_push      = bus.cmd_valid && w_cmd_ready;
   assign w_head      = r_mem[r_rd_ptr];

   // A pop happens when the FSM is free to take a new command: from IDLE, or
   // from HOLD at the edge the current result is handed off.
   assign w_pop = !w_empty &&
                  ((r_state == S_IDLE) ||
                   ((r_state == S_HOLD) && bus.res_ready));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
      end
   end

   // Pointers are c_AW bits wide, so wrap modulo DEPTH is implicit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_AW + 1)'(1);
            2'b01:   r_count <= r_count - (c_AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Issue / capture FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_cf    <= 1'b0;
         r_res_sf    <= 1'b0;
         r_res_zf    <= 1'b0;
      end else begin
         // ALU operands move only on a pop, keeping the ALU inputs stable
         // through the whole ISSUE cycle and the following HOLD.
         if (w_pop) begin
            r_alu_op <= w_head[c_EW-1];
            r_alu_a  <= w_head[2*WIDTH-1:WIDTH];
            r_alu_b  <= w_head[WIDTH-1:0];
         end

         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_res_data  <= bus.alu_result;
               r_res_cf    <= bus.alu_cf;
               r_res_sf    <= bus.alu_sf;
               r_res_zf    <= bus.alu_zf;
               r_res_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= w_empty ? S_IDLE : S_ISSUE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ISSUE_OPCNT_EN
   // ------------------------------------------------------------------------
   // Saturating result-handshake counter
   // ------------------------------------------------------------------------
   logic [7:0] r_op_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_count <= 8'd0;
      end else if (r_res_valid && bus.res_ready && (r_op_count != 8'hFF)) begin
         r_op_count <= r_op_count + 8'd1;
      end
   end

   assign op_count = r_op_count;
`endif

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_op    = r_alu_op;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_cf    = r_res_cf;
   assign bus.res_sf    = r_res_sf;
   assign bus.res_zf    = r_res_zf;
   assign busy          = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front/back end for the combinational 7-bit ALU (ports A, B, OP, result, CF, SF, ZF).
- Buffers incoming operand commands in a small FIFO and drives registered, stable operands into the ALU.
- Captures the ALU result and flags one cycle later and presents them on a valid/ready result interface.
- Converts the purely combinational ALU into a flow-controlled pipeline stage for the surrounding datapath.

Parameters:
- WIDTH, 7, operand/result width. Must match the ALU.
- DEPTH, 4, command FIFO entries. Power of 2, at least 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset. Sampled on the clk rising edge.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  1  0 = add, 1 = subtract (ALU OP encoding).
- alu_a  out  WIDTH  registered, to ALU A.
- alu_b  out  WIDTH  registered, to ALU B.
- alu_op  out  1  registered, to ALU OP.
- alu_result  in  WIDTH  from ALU result.
- alu_cf  in  1  from ALU CF.
- alu_sf  in  1  from ALU SF.
- alu_zf  in  1  from ALU ZF.
- res_valid  out  1  result/flags valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- res_cf  out  1  captured CF.
- res_sf  out  1  captured SF.
- res_zf  out  1  captured ZF.
- busy  out  1  high when state != IDLE or FIFO not empty.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO pointers and count = 0; state = IDLE.
  - alu_a = alu_b = 0, alu_op = 0.
  - res_valid = 0; res_data, res_cf, res_sf, res_zf = 0.
  - cmd_ready = 1 from the first cycle after reset. busy = 0.
- FIFO:
  - Entry is {op, a, b}, 2*WIDTH+1 bits.
  - Push on cmd_valid && cmd_ready. cmd_ready = (count != DEPTH), driven from registered count with no combinational bypass. When full, a pop in the same cycle does not raise cmd_ready until the next cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: if FIFO not empty, pop head into alu_a/alu_b/alu_op and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: ALU inputs have been stable for one full cycle. At the edge, capture alu_result and the flags into the res_* registers, set res_valid = 1, go to HOLD.
  - HOLD: res_* held constant while res_valid && !res_ready.
    - On res_ready, clear res_valid.
    - If the FIFO is not empty at that edge, pop the next entry into the alu_* registers and go to ISSUE (back-to-back).
    - Otherwise go to IDLE.
- Latency: a command pushed at edge t into an empty FIFO in IDLE is popped at t+1 and its result is valid after edge t+2.
- Throughput: one result per 2 cycles with res_ready held high.
- Width rules: no arithmetic in this block. Result and flags pass through unmodified from the ALU. alu_* outputs change only on a pop.
- Back-pressure: if res_ready stays low, the FSM stays in HOLD. The FIFO keeps accepting commands until full, then cmd_ready = 0.
- Reset mid-operation: the pending result and all FIFO contents are discarded. No partial res_valid pulse.

Optional Feature:
- Macro: ALU_ISSUE_OPCNT_EN.
- Defined:
  - Adds output op_count [7:0].
  - Increments on each result handshake (res_valid && res_ready), saturating at 255.
  - Cleared by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Single add: push a=0000100, b=0000011, op=0, res_ready=1 -> res_valid 2 cycles after the push edge; res_data=0000111, cf=0, zf=0, sf=0. busy returns to 0 after the handshake.
- Single subtract: a=0001100, b=0000010, op=1 -> res_data=0001010, zf=0, sf=0. alu_op=1 is held for the whole ISSUE cycle.
- Fill and back-pressure: res_ready=0, push 5 commands.
  - The first is popped into the ALU; the next 4 fill the FIFO, then cmd_ready=0.
  - Raise res_ready -> results emerge in push order, one every 2 cycles.
  - cmd_ready reasserts the cycle after the first FIFO pop following full.
- Zero result: a=0000101, b=0000101, op=1 -> res_data=0000000, zf=1. res_* stable while res_ready=0 for 3 cycles.
- Reset mid-operation: with 3 commands queued and one in HOLD, assert rst_n=0 for 1 cycle.
  - res_valid=0, cmd_ready=1, busy=0; no stale results afterwards.
  - With ALU_ISSUE_OPCNT_EN defined, op_count=0.
- Counter saturation (ALU_ISSUE_OPCNT_EN defined): 260 handshakes -> op_count=255.
